// File: rtl/dmem_mmio_bridge.sv
// rtl/dmem_mmio_bridge.sv - data RAM plus MMIO window (TX FIFO, status, drops, optional cycle counter via DMEM_CYCLE_CNT_EN)
module dmem_mmio_bridge #(
  parameter int ADDR_W  = 8,
  parameter int FIFO_AW = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_adr,
  input  logic [31:0] data_wr,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] data_rd,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int RAM_WORDS = 1 << ADDR_W;
  localparam int DEPTH     = 1 << FIFO_AW;
  localparam int CW        = FIFO_AW + 1;

  localparam logic [15:0] OFF_TXDATA = 16'h0000;
  localparam logic [15:0] OFF_STATUS = 16'h0004;
  localparam logic [15:0] OFF_CYCLE  = 16'h0008;
  localparam logic [15:0] OFF_DROPS  = 16'h000C;

  // Data RAM
  logic [31:0] mem_q [RAM_WORDS];
  logic [31:0] mem_d [RAM_WORDS];

  // TX FIFO storage and bookkeeping
  logic [7:0]         fifo_mem_q [DEPTH];
  logic [7:0]         fifo_mem_d [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [15:0]        drops_q, drops_d;

`ifdef DMEM_CYCLE_CNT_EN
  logic [31:0] cycle_q, cycle_d;
`endif

  // Decode results
  logic              is_mmio;
  logic [15:0]       mmio_off;
  logic [ADDR_W-1:0] ram_idx;
  logic              ram_we;
  logic              push_req;
  logic              pop;
  logic              push_ok;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [31:0]       status_word;
  logic [31:0]       cycle_word;

  assign is_mmio  = (data_adr[31:16] == 16'hFFFF);
  assign mmio_off = data_adr[15:0];
  assign ram_idx  = data_adr[ADDR_W+1:2];

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(DEPTH));
  assign tx_valid   = !fifo_empty;
  assign tx_data    = tx_valid ? fifo_mem_q[rd_ptr_q] : 8'h00;

  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign ram_we   = mem_write && !is_mmio;
  assign push_req = mem_write && is_mmio && (mmio_off == OFF_TXDATA);
  assign pop      = tx_valid && tx_ready;
  assign push_ok  = push_req && (!fifo_full || pop);
  assign drop     = push_req && fifo_full && !pop;

  assign status_word = {16'h0000, 8'(count_q), 6'b000000, fifo_full, fifo_empty};

`ifdef DMEM_CYCLE_CNT_EN
  assign cycle_word = cycle_q;
`else
  assign cycle_word = 32'h0000_0000;
`endif

  // Load data mux: RAM or MMIO register, zero when no load is requested
  always_comb begin
    data_rd = 32'h0000_0000;
    if (mem_read) begin
      if (is_mmio) begin
        unique case (mmio_off)
          OFF_STATUS: data_rd = status_word;
          OFF_CYCLE:  data_rd = cycle_word;
          OFF_DROPS:  data_rd = {16'h0000, drops_q};
          default:    data_rd = 32'h0000_0000;
        endcase
      end else begin
        data_rd = mem_q[ram_idx];
      end
    end
  end

  // Next RAM contents: single word store
  always_comb begin
    mem_d = mem_q;
    if (ram_we) begin
      mem_d[ram_idx] = data_wr;
    end
  end

  // Next FIFO state: push/pop pointer moves, occupancy and drop counting
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drops_d    = drops_q;
    if (push_ok) begin
      fifo_mem_d[wr_ptr_q] = data_wr[7:0];
      wr_ptr_d             = wr_ptr_q + FIFO_AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    end
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (drop && (drops_q != 16'hFFFF)) begin
      drops_d = drops_q + 16'd1;
    end
  end

  // State registers for RAM, FIFO and drop counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q      <= '{default: 32'h0000_0000};
      fifo_mem_q <= '{default: 8'h00};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drops_q    <= 16'h0000;
    end else begin
      mem_q      <= mem_d;
      fifo_mem_q <= fifo_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drops_q    <= drops_d;
    end
  end

`ifdef DMEM_CYCLE_CNT_EN
  // Free-running cycle counter, wraps naturally
  always_comb begin
    cycle_d = cycle_q + 32'd1;
  end

  // Cycle counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q <= 32'h0000_0000;
    end else begin
      cycle_q <= cycle_d;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// tb/tb_dmem_mmio_bridge.sv - self-checking bench for dmem_mmio_bridge
module tb_dmem_mmio_bridge;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_adr;
  logic [31:0] data_wr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] data_rd;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Behavioural model state
  logic [31:0] m_ram [256];
  logic [7:0]  m_q [$];
  int          m_drops = 0;
  logic [31:0] m_cyc = 32'h0;

  dmem_mmio_bridge #(.ADDR_W(8), .FIFO_AW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_adr  (data_adr),
    .data_wr   (data_wr),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .data_rd   (data_rd),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_rd();
    logic [31:0] r;
    r = 32'h0;
    if (mem_read) begin
      if (data_adr[31:16] == 16'hFFFF) begin
        case (data_adr[15:0])
          16'h0004: r = (m_q.size() << 8) | ((m_q.size() == DEPTH) ? 2 : 0) | ((m_q.size() == 0) ? 1 : 0);
`ifdef DMEM_CYCLE_CNT_EN
          16'h0008: r = m_cyc;
`endif
          16'h000C: r = m_drops;
          default:  r = 32'h0;
        endcase
      end else begin
        r = m_ram[data_adr[9:2]];
      end
    end
    return r;
  endfunction

  // Model update: same rules as the block, applied to queue/array state
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_drops = 0;
      m_cyc = 32'h0;
      foreach (m_ram[i]) m_ram[i] = 32'h0;
    end else begin
      int  pre;
      bit  popped;
      pre = m_q.size();
      popped = (pre > 0) && tx_ready;
      if (popped) void'(m_q.pop_front());
      if (mem_write && data_adr[31:16] == 16'hFFFF && data_adr[15:0] == 16'h0000) begin
        if (pre < DEPTH || popped) m_q.push_back(data_wr[7:0]);
        else if (m_drops < 65535) m_drops++;
      end
      if (mem_write && data_adr[31:16] != 16'hFFFF) m_ram[data_adr[9:2]] = data_wr;
      m_cyc = m_cyc + 1;
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_data_rd", data_rd, m_rd());
      chk("cyc_tx_valid", {31'h0, tx_valid}, {31'h0, m_q.size() != 0});
      chk("cyc_tx_data", {24'h0, tx_data}, {24'h0, (m_q.size() != 0) ? m_q[0] : 8'h00});
    end
  end

  task automatic drive(input logic [31:0] adr, input logic [31:0] wd,
                       input logic rd, input logic wr, input logic rdy);
    @(posedge clk);
    #1;
    data_adr  = adr;
    data_wr   = wd;
    mem_read  = rd;
    mem_write = wr;
    tx_ready  = rdy;
    #2;
  endtask

  initial begin
    logic [7:0] drain_exp [4];
    drain_exp[0] = 8'h42; drain_exp[1] = 8'h43; drain_exp[2] = 8'h44; drain_exp[3] = 8'h46;
    foreach (m_ram[i]) m_ram[i] = 32'h0;
    rst = 1'b1;
    data_adr = 32'h0; data_wr = 32'h0; mem_read = 1'b0; mem_write = 1'b0; tx_ready = 1'b0;
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
    chk("rst_data_rd", data_rd, 32'h0);

    // Cycle counter: read at the 10th edge after release
    data_adr = 32'hFFFF_0008; mem_read = 1'b1; rst = 1'b0;
    repeat (10) @(posedge clk);
    #2;
`ifdef DMEM_CYCLE_CNT_EN
    chk("cycle_10", data_rd, 32'd10);
`else
    chk("cycle_off", data_rd, 32'h0);
`endif

    // RAM store / load and aliasing
    drive(32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
    drive(32'h0000_0010, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("ram_rd_10", data_rd, 32'hDEAD_BEEF);
    drive(32'h0000_0410, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("ram_alias_410", data_rd, 32'hDEAD_BEEF);
    drive(32'h0000_0013, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("ram_byteoff_13", data_rd, 32'hDEAD_BEEF);
    drive(32'h0000_0014, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("ram_rd_14", data_rd, 32'h0);

    // Same-cycle read and write
    drive(32'h0000_0020, 32'h5, 1'b1, 1'b1, 1'b0);
    chk("rw_old", data_rd, 32'h0);
    drive(32'h0000_0020, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("rw_new", data_rd, 32'h5);

    // Fill FIFO past full with sink stalled
    for (int i = 0; i < 5; i++) drive(32'hFFFF_0000, 32'h41 + i, 1'b0, 1'b1, 1'b0);
    drive(32'hFFFF_0004, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("status_full", data_rd, 32'h0000_0402);
    chk("head_41", {24'h0, tx_data}, 32'h41);
    drive(32'hFFFF_000C, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("drops_1", data_rd, 32'h1);
    drive(32'hFFFF_0000, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("txdata_reads_0", data_rd, 32'h0);

    // Push and pop together while full
    drive(32'hFFFF_0000, 32'h46, 1'b0, 1'b1, 1'b1);
    drive(32'hFFFF_0004, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("status_full_pp", data_rd, 32'h0000_0402);
    for (int i = 0; i < 4; i++) begin
      drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      chk("drain_valid", {31'h0, tx_valid}, 32'h1);
      chk("drain_data", {24'h0, tx_data}, {24'h0, drain_exp[i]});
    end
    drive(32'hFFFF_0004, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("empty_valid", {31'h0, tx_valid}, 32'h0);
    chk("status_empty", data_rd, 32'h0000_0001);

    // Asynchronous reset mid-cycle with bytes queued
    drive(32'hFFFF_0000, 32'h11, 1'b0, 1'b1, 1'b0);
    drive(32'hFFFF_0000, 32'h22, 1'b0, 1'b1, 1'b0);
    drive(32'hFFFF_0000, 32'h33, 1'b0, 1'b1, 1'b0);
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_valid", {31'h0, tx_valid}, 32'h1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'h0, tx_valid}, 32'h0);
    chk("async_rst_data", {24'h0, tx_data}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(32'hFFFF_0004, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("status_after_rst", data_rd, 32'h0000_0001);
    drive(32'h0000_0010, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("ram_cleared", data_rd, 32'h0);
    drive(32'hFFFF_000C, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("drops_cleared", data_rd, 32'h0);

    @(posedge clk);
    #1;
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_mmio_bridge.md
Name: dmem_mmio_bridge

Overview:
- Data-side memory block directly downstream of the single-cycle MIPS core's data port.
- Consumes the core's data_adr, store data and mem_read/mem_write, and returns load data in the same cycle.
- Contains the word-addressed data RAM plus a small MMIO window: a byte TX FIFO drained over valid/ready, a status register, a drop counter and an optional cycle counter.

Parameters:
ADDR_W, 8, RAM word-address width (2^ADDR_W words of 32 bits)
FIFO_AW, 2, TX FIFO pointer width (depth 2^FIFO_AW; legal 1..3)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
data_adr  input  32  byte address from core
data_wr  input  32  store data from core
mem_read  input  1  load strobe
mem_write  input  1  store strobe
data_rd  output  32  load data to core, combinational
tx_valid  output  1  TX FIFO non-empty
tx_data  output  8  TX FIFO head byte
tx_ready  input  1  sink accepts head byte this cycle

Behaviour:
- Reset is asynchronous and active-high on rst, single clock clk.
- Reset clears all RAM words, FIFO pointers and count, drop counter and cycle counter. Outputs after reset: tx_valid=0, tx_data=0, data_rd=0 when mem_read=0.
- Decode:
  - data_adr[31:16]==16'hFFFF selects MMIO. Otherwise the access goes to RAM, word index data_adr[ADDR_W+1:2]. Upper bits and data_adr[1:0] are ignored, so addresses alias/wrap.
- RAM:
  - Read is combinational: data_rd = mem[idx] while mem_read=1, else 32'h0.
  - Write occurs at posedge when mem_write=1.
  - When mem_read and mem_write are both 1 on the same word, data_rd shows the old value that cycle and the new value from the next cycle.
- MMIO map (offset = data_adr[15:0]); unlisted offsets read 0 and ignore writes:
  - 0x0000 TXDATA: a write pushes data_wr[7:0]; reads 0.
  - 0x0004 STATUS (read-only): bit0 empty, bit1 full, bits[15:8] count zero-extended, rest 0.
  - 0x0008 CYCLE (read-only): free-running 32-bit counter, +1 every clk, wraps. A read returns the pre-increment value.
  - 0x000C DROPS (read-only): 16-bit count of rejected pushes, saturates at 16'hFFFF; upper bits read 0.
- TX FIFO:
  - tx_valid = (count!=0).
  - tx_data = head entry when valid, else 8'h0.
  - Pop occurs when tx_valid && tx_ready at posedge.
  - Push is accepted if not full, or if full with a pop in the same cycle (count unchanged, both pointers advance).
  - Push while full with no pop: byte dropped, DROPS increments, FIFO unchanged.
  - Push into an empty FIFO: tx_valid=1 from the next cycle. No same-cycle bypass.
  - Push and pop on a non-empty, non-full FIFO: count unchanged.
  - Pointers wrap modulo 2^FIFO_AW; count is FIFO_AW+1 bits.
- rst asserted mid-operation immediately clears everything, including queued bytes. No partial state survives.
- The block never stalls the core. Every access completes in the cycle it is presented.

Optional Feature:
- Macro DMEM_CYCLE_CNT_EN.
- Defined: CYCLE register is implemented as described above.
- Undefined: no counter flops are built and offset 0x0008 reads 32'h0. All other behaviour is identical.

Test Plan:
- Reset then store 32'hDEADBEEF to 0x00000010, then load 0x00000010 and 0x00000410 (alias with ADDR_W=8) -> both return 32'hDEADBEEF; 0x00000014 returns 0.
- Same-cycle read+write to 0x20 (old 0, new 32'h5) -> data_rd=0 that cycle, 32'h5 next cycle.
- tx_ready=0, write 0x41,0x42,0x43,0x44,0x45 to 0xFFFF0000 (depth 4) -> STATUS=32'h00000402, DROPS=1, tx_data=0x41.
- From full, tx_ready=1 while pushing 0x46 in the same cycle -> count stays 4; subsequent drain order 0x42,0x43,0x44,0x46; then tx_valid=0, STATUS=32'h00000001.
- With DMEM_CYCLE_CNT_EN, release reset and read 0xFFFF0008 at the 10th clk edge after release -> 32'd10 (pre-increment). Without the macro -> 32'h0.
- Assert rst asynchronously mid-clock with 3 bytes queued -> tx_valid drops to 0 immediately; STATUS reads 32'h00000001 after release.
